// File: rtl/multu_hilo_unit_if.sv
// ----------------------------------------------------------------------------
// multu_hilo_unit_if : request/response bundle between the issuing stage and
//                      the MULTU/MFHI/MFLO execute unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface multu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [1:0]       ALUOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] dataOut;
  logic             outValid;

  modport master (
    output req, ALUOp, Funct, dataA, dataB,
    input  busy, stall, done, dataOut, outValid
  );

  modport slave (
    input  req, ALUOp, Funct, dataA, dataB,
    output busy, stall, done, dataOut, outValid
  );
endinterface

`default_nettype wire

// File: rtl/multu_hilo_unit.sv
// ----------------------------------------------------------------------------
// multu_hilo_unit : multi-cycle shift-add MULTU into HI/LO with MFHI/MFLO reads.
//                   Optional early exit controlled by MULTU_EARLY_EXIT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multu_hilo_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] F_MULTU = 6'b011001,
  parameter logic [5:0] F_MFHI  = 6'b010000,
  parameter logic [5:0] F_MFLO  = 6'b010010
) (
  input  wire logic         clk,
  input  wire logic         rst,
  multu_hilo_unit_if.slave  bus
);

  localparam int         CW     = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] w_p_step;
  logic [2*WIDTH-1:0] w_p_final;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_dout;
  logic [CW-1:0]      r_cnt;
  logic               r_ovalid;
  logic [WIDTH:0]     w_sum;
  logic               w_ours;
  logic               w_take;
  logic               w_start;
  logic               w_last;

  assign w_ours  = bus.req && (bus.ALUOp == 2'b10) &&
                   ((bus.Funct == F_MULTU) || (bus.Funct == F_MFHI) || (bus.Funct == F_MFLO));
  assign w_take  = w_ours && (r_state != S_MUL);
  assign w_start = w_take && (bus.Funct == F_MULTU);

  // Upper half accumulates the multiplicand; the carry lands in the shifted-in MSB.
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_p_step = {w_sum, r_p[WIDTH-1:1]};

`ifdef MULTU_EARLY_EXIT_EN
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    w_shamt;

  // r_q mirrors the multiplier bits not yet consumed; once none remain after
  // this step, the rest of the multiply is a pure right shift.
  assign w_shamt   = CW'(WIDTH - 1) - r_cnt;
  assign w_last    = (r_cnt == CW'(WIDTH - 1)) || (r_q[WIDTH-1:1] == '0);
  assign w_p_final = w_p_step >> w_shamt;
`else
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_p_final = w_p_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_start ? S_MUL : S_IDLE;
      S_MUL:          w_state_nxt = w_last ? S_DONE : S_MUL;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (r_state == S_MUL);
    bus.done  = (r_state == S_DONE);
    bus.stall = w_ours && (r_state == S_MUL);
  end

  assign bus.dataOut  = r_dout;
  assign bus.outValid = r_ovalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dout   <= '0;
      r_ovalid <= 1'b0;
`ifdef MULTU_EARLY_EXIT_EN
      r_q      <= '0;
`endif
    end else begin
      r_ovalid <= 1'b0;
      if (w_start) begin
        r_p   <= {{WIDTH{1'b0}}, bus.dataB};
        r_m   <= bus.dataA;
        r_cnt <= '0;
`ifdef MULTU_EARLY_EXIT_EN
        r_q   <= bus.dataB;
`endif
      end else if (r_state == S_MUL) begin
        r_p   <= w_p_step;
        r_cnt <= r_cnt + 1'b1;
`ifdef MULTU_EARLY_EXIT_EN
        r_q   <= r_q >> 1;
`endif
        if (w_last) begin
          {r_hi, r_lo} <= w_p_final;
        end
      end
      if (w_take && (bus.Funct == F_MFHI)) begin
        r_dout   <= r_hi;
        r_ovalid <= 1'b1;
      end else if (w_take && (bus.Funct == F_MFLO)) begin
        r_dout   <= r_lo;
        r_ovalid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multu_hilo_unit.sv
// ----------------------------------------------------------------------------
// tb_multu_hilo_unit : scoreboard bench for multu_hilo_unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multu_hilo_unit;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multu_hilo_unit_if #(.WIDTH(32)) bus ();

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] out_q[$];
  int          cyc_q[$];
  int          busy_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int exp_cycles(input logic [31:0] b);
    int n;
`ifdef MULTU_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  // Present one request, hold it while stalled, release after the accepting edge.
  task automatic issue(input logic [1:0] alu, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output bit in_done);
    logic [63:0] prod;
    @(negedge clk);
    bus.req = 1'b1; bus.ALUOp = alu; bus.Funct = fn; bus.dataA = a; bus.dataB = b;
    stalls = 0;
    #1;
    while (bus.stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    in_done = bus.done;
    if (alu == 2'b10) begin
      if (fn == F_MULTU) begin
        prod = 64'(a) * 64'(b);
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        cyc_q.push_back(exp_cycles(b));
      end else if (fn == F_MFHI) begin
        out_q.push_back(m_hi);
      end else if (fn == F_MFLO) begin
        out_q.push_back(m_lo);
      end
    end
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      cyc_q.delete();
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        check_eq("done_pending", 64'(cyc_q.size() > 0), 64'd1);
        if (cyc_q.size() > 0) check_eq("mul_cycles", 64'(busy_cnt), 64'(cyc_q.pop_front()));
        busy_cnt = 0;
      end
      if (bus.outValid) begin
        check_eq("outvalid_pending", 64'(out_q.size() > 0), 64'd1);
        if (out_q.size() > 0) check_eq("dataOut", 64'(bus.dataOut), 64'(out_q.pop_front()));
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((out_q.size() > 0 || cyc_q.size() > 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    #1;
    check_eq("out_q_drained", 64'(out_q.size()), 64'd0);
    check_eq("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
  endtask

  int st;
  bit dn;
  logic [31:0] ra, rb;

  initial begin
    bus.req = 1'b0; bus.ALUOp = 2'b00; bus.Funct = 6'd0; bus.dataA = '0; bus.dataB = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_outValid", 64'(bus.outValid), 64'd0);
    check_eq("rst_dataOut", 64'(bus.dataOut), 64'd0);
    check_eq("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b10, F_MFHI, '0, '0, st, dn);
    issue(2'b10, F_MFLO, '0, '0, st, dn);

    // Small product, then a read issued one cycle later must stall until DONE.
    issue(2'b10, F_MULTU, 32'd3, 32'd5, st, dn);
    issue(2'b10, F_MFHI, '0, '0, st, dn);
    check_eq("mfhi_stalls", 64'(st), 64'(exp_cycles(32'd5)));
    check_eq("mfhi_in_done", 64'(dn), 64'd1);
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    check_eq("mflo_no_stall", 64'(st), 64'd0);

    // All-ones operands exercise the carry out of every add.
    issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, dn);
    issue(2'b10, F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, st, dn);
    check_eq("multu_held_stalls", 64'(st), 64'(exp_cycles(32'hFFFF_FFFF)));
    check_eq("multu_held_in_done", 64'(dn), 64'd1);
    issue(2'b10, F_MFHI, '0, '0, st, dn);
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    wait_drain();

    issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, dn);
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    issue(2'b10, F_MFHI, '0, '0, st, dn);

    // Not-ours traffic: wrong ALUOp and an unrelated funct are both ignored.
    issue(2'b00, F_MULTU, 32'd9, 32'd9, st, dn);
    check_eq("notours_busy", 64'(bus.busy), 64'd0);
    issue(2'b10, 6'b100000, 32'd9, 32'd9, st, dn);
    check_eq("notours_funct_busy", 64'(bus.busy), 64'd0);
    issue(2'b10, F_MULTU, 32'd11, 32'hFFFF_FFFF, st, dn);
    @(negedge clk);
    bus.req = 1'b1; bus.ALUOp = 2'b01; bus.Funct = F_MFHI;
    #1;
    check_eq("notours_no_stall_busy", 64'(bus.stall), 64'd0);
    bus.req = 1'b0;
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    issue(2'b10, F_MFHI, '0, '0, st, dn);
    wait_drain();

    // Reset mid-multiply discards the partial product.
    issue(2'b10, F_MULTU, 32'hDEAD_BEEF, 32'hFFFF_FFFF, st, dn);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    issue(2'b10, F_MFHI, '0, '0, st, dn);
    wait_drain();

    // Short multipliers (early-exit lengths when that build is selected).
    issue(2'b10, F_MULTU, 32'd7, 32'd3, st, dn);
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    issue(2'b10, F_MULTU, 32'hABCD_0123, 32'd0, st, dn);
    issue(2'b10, F_MFHI, '0, '0, st, dn);
    issue(2'b10, F_MFLO, '0, '0, st, dn);
    issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'h8000_0000, st, dn);
    issue(2'b10, F_MFHI, '0, '0, st, dn);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      issue(2'b10, F_MULTU, ra, rb, st, dn);
      issue(2'b10, F_MFHI, '0, '0, st, dn);
      issue(2'b10, F_MFLO, '0, '0, st, dn);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
